backscatter_frame_tx: RTL and testbench

- Frame source directly upstream of the switch-control/process stage in the backscatter tag.
- On a debounced key press, or a start pulse, it latches a payload and serialises preamble + payload + CRC-8 as a timed bit stream.
- The downstream stage consumes tx_en/tx_bit/bit_stb and maps each bit onto its ctrl1..ctrl4 modulation pattern.
- Runs entirely in the 12 MHz board clock domain.

---
 rtl/backscatter_pkg.sv | 23 ++
 rtl/backscatter_frame_tx_if.sv | 23 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/backscatter_frame_tx.sv | 156 +++++++++++++++
 tb/tb_backscatter_frame_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/backscatter_pkg.sv
// Shared types and constants for the backscatter frame source.
// The serial CRC-8 step used by the frame transmitter also lives here.
package backscatter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    CRC,
    GAP
  } state_t;

  localparam int             CRC_W        = 8;
  localparam logic [CRC_W-1:0] CRC8_POLY  = 8'h07;
  localparam logic [15:0]    DEF_PREAMBLE = 16'hAAAA;

  // x^8+x^2+x+1, MSB-first, one bit per call
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b);
    return {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ b) ? CRC8_POLY : '0);
  endfunction

endpackage

// File: rtl/backscatter_frame_tx_if.sv
// Start/payload request side and serial bit-stream side of the frame source.
interface backscatter_frame_tx_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 start;
  logic [PAYLOAD_W-1:0] payload;
  logic                 tx_en;
  logic                 tx_bit;
  logic                 bit_stb;
  logic                 busy;
  logic                 frame_done;
  logic [7:0]           frame_cnt;

  modport master (
    output start, payload,
    input  tx_en, tx_bit, bit_stb, busy, frame_done, frame_cnt
  );

  modport slave (
    input  start, payload,
    output tx_en, tx_bit, bit_stb, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for an active-low key.
// Emits a one-cycle pulse on each debounced press (1 -> 0).
module key_debounce #(
  parameter int DEBOUNCE_CYC = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchroniser and level reset to "released" so leaving reset never fakes a press.
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      level       <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          level       <= sync2;
          cnt         <= '0;
          press_pulse <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/backscatter_frame_tx.sv
// Frame source: on key press or start, sends preamble + payload + CRC-8
// as a timed bit stream, then holds off for a gap before the next frame.
module backscatter_frame_tx
  import backscatter_pkg::*;
#(
  parameter int                BIT_CYC      = 1200,
  parameter int                DEBOUNCE_CYC = 240000,
  parameter int                PRE_W        = 16,
  parameter logic [PRE_W-1:0]  PREAMBLE     = DEF_PREAMBLE,
  parameter int                PAYLOAD_W    = 32,
  parameter int                GAP_BITS     = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  key_n,
  backscatter_frame_tx_if.slave bus
);

  localparam int CYC_W    = $clog2(BIT_CYC);
  localparam int MAX_BITS = (PRE_W > PAYLOAD_W) ?
                            ((PRE_W > GAP_BITS) ? PRE_W : GAP_BITS) :
                            ((PAYLOAD_W > GAP_BITS) ? PAYLOAD_W : GAP_BITS);
  localparam int IDX_W    = $clog2((MAX_BITS > CRC_W) ? MAX_BITS : CRC_W);

  state_t               state;
  logic [CYC_W-1:0]     cyc;
  logic [IDX_W-1:0]     idx;
  logic [PRE_W-1:0]     pre_sr;
  logic [PAYLOAD_W-1:0] data_sr;
  logic [CRC_W-1:0]     crc;
  logic                 tx_en;
  logic                 tx_bit;
  logic                 bit_stb;
  logic                 busy;
  logic                 frame_done;
  logic [7:0]           frame_cnt;
  logic                 press;
  logic                 req;
  logic                 wrap;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .press_pulse (press)
  );

  assign req  = press | bus.start;
  assign wrap = (cyc == CYC_W'(BIT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cyc        <= '0;
      idx        <= '0;
      pre_sr     <= '0;
      data_sr    <= '0;
      crc        <= '0;
      tx_en      <= 1'b0;
      tx_bit     <= 1'b0;
      bit_stb    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      bit_stb    <= 1'b0;
      frame_done <= 1'b0;
      if (state != IDLE) cyc <= wrap ? '0 : cyc + 1'b1;

      case (state)
        IDLE: if (req) begin
          state   <= PRE;
          cyc     <= '0;
          idx     <= '0;
          data_sr <= bus.payload;
          crc     <= '0;
          pre_sr  <= PREAMBLE << 1;
          busy    <= 1'b1;
          tx_en   <= 1'b1;
          bit_stb <= 1'b1;
          tx_bit  <= PREAMBLE[PRE_W-1];
        end

        PRE: if (wrap) begin
          bit_stb <= 1'b1;
          if (idx == IDX_W'(PRE_W - 1)) begin
            state   <= DATA;
            idx     <= '0;
            tx_bit  <= data_sr[PAYLOAD_W-1];
            crc     <= crc8_step(crc, data_sr[PAYLOAD_W-1]);
            data_sr <= data_sr << 1;
          end else begin
            idx    <= idx + 1'b1;
            tx_bit <= pre_sr[PRE_W-1];
            pre_sr <= pre_sr << 1;
          end
        end

        // The CRC absorbs each data bit as it is launched, so it is final
        // by the time the last data bit ends.
        DATA: if (wrap) begin
          bit_stb <= 1'b1;
          if (idx == IDX_W'(PAYLOAD_W - 1)) begin
            state  <= CRC;
            idx    <= '0;
            tx_bit <= crc[CRC_W-1];
            crc    <= crc << 1;
          end else begin
            idx     <= idx + 1'b1;
            tx_bit  <= data_sr[PAYLOAD_W-1];
            crc     <= crc8_step(crc, data_sr[PAYLOAD_W-1]);
            data_sr <= data_sr << 1;
          end
        end

        CRC: if (wrap) begin
          if (idx == IDX_W'(CRC_W - 1)) begin
            state      <= GAP;
            idx        <= '0;
            tx_en      <= 1'b0;
            tx_bit     <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end else begin
            bit_stb <= 1'b1;
            idx     <= idx + 1'b1;
            tx_bit  <= crc[CRC_W-1];
            crc     <= crc << 1;
          end
        end

        GAP: if (wrap) begin
          if (idx == IDX_W'(GAP_BITS - 1)) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_en      = tx_en;
  assign bus.tx_bit     = tx_bit;
  assign bus.bit_stb    = bit_stb;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_backscatter_frame_tx.sv
// Directed bench for backscatter_frame_tx: expected bits are queued when a
// frame is launched and popped on every bit_stb.
module tb_backscatter_frame_tx;

  localparam int BIT_CYC    = 4;
  localparam int DEB_CYC    = 8;
  localparam int GAP_BITS   = 2;
  localparam int PAYLOAD_W  = 32;
  localparam int FRAME_BITS = 16 + 32 + 8;

  logic clk = 1'b0;
  logic rst;
  logic key_n;

  always #5 clk = ~clk;

  backscatter_frame_tx_if #(.PAYLOAD_W(PAYLOAD_W)) bus ();

  backscatter_frame_tx #(
    .BIT_CYC      (BIT_CYC),
    .DEBOUNCE_CYC (DEB_CYC),
    .PAYLOAD_W    (PAYLOAD_W),
    .GAP_BITS     (GAP_BITS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_n),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_cnt     = 0;
  logic exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_model(input logic [31:0] d);
    logic [7:0] c = 8'h00;
    logic       fb;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic push_frame(input logic [31:0] pl, input logic [7:0] c);
    logic [15:0] pre = 16'hAAAA;
    for (int i = 15; i >= 0; i--) exp_q.push_back(pre[i]);
    for (int i = 31; i >= 0; i--) exp_q.push_back(pl[i]);
    for (int i = 7; i >= 0; i--)  exp_q.push_back(c[i]);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge and
  // scrambles payload to prove it was latched.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.payload = ~bus.payload;
  endtask

  // Expects the frame's first cycle at the current negedge; returns at the
  // first negedge with busy low.
  task automatic watch_frame(input string tag, input int poke_stb, input bit poke_gap);
    int stb = 0, en = 0, done = 0, last = 0, cyc = 0, done_at = -1000;
    check({tag, " start"}, bus.tx_en, 1'b1);
    if (!bus.tx_en) begin
      exp_q.delete();
      return;
    end
    check({tag, " first_stb"}, bus.bit_stb, 1'b1);
    exp_cnt++;
    while (bus.busy && cyc < 400) begin
      bus.start = 1'b0;
      if (bus.tx_en) en++;
      if (bus.bit_stb) begin
        if (stb > 0) check({tag, " stb_spacing"}, cyc - last, BIT_CYC);
        last = cyc;
        if (exp_q.size() > 0) check({tag, " tx_bit"}, bus.tx_bit, exp_q.pop_front());
        stb++;
        if (stb == poke_stb) bus.start = 1'b1;
      end
      if (bus.frame_done) begin
        done++;
        done_at = cyc;
        check({tag, " end_tx_en"}, bus.tx_en, 1'b0);
        check({tag, " end_tx_bit"}, bus.tx_bit, 1'b0);
        if (poke_gap) bus.start = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " busy_end"}, bus.busy, 1'b0);
    check({tag, " stb_count"}, stb, FRAME_BITS);
    check({tag, " tx_en_cycles"}, en, FRAME_BITS * BIT_CYC);
    check({tag, " done_count"}, done, 1);
    check({tag, " gap_len"}, cyc - done_at, GAP_BITS * BIT_CYC);
    check({tag, " frame_cnt"}, bus.frame_cnt, exp_cnt[7:0]);
    check({tag, " idle_tx_bit"}, bus.tx_bit, 1'b0);
    check({tag, " queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input string tag, input logic [31:0] pl, input logic [7:0] c);
    bus.payload = pl;
    push_frame(pl, c);
    pulse_start();
    watch_frame(tag, -1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pl;
    bit          seen;
    int          stb;
    int          cyc;

    // Reset with start held high: nothing may launch
    rst = 1'b1; key_n = 1'b1; bus.start = 1'b1; bus.payload = 32'h00000001;
    repeat (3) @(negedge clk);
    check("rst tx_en", bus.tx_en, 1'b0);
    check("rst busy", bus.busy, 1'b0);
    check("rst outs", {bus.tx_bit, bus.bit_stb, bus.frame_done}, 3'b000);
    check("rst frame_cnt", bus.frame_cnt, 8'h00);
    rst = 1'b0; bus.start = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= bus.tx_en | bus.busy; end
    check("post_rst idle", seen, 1'b0);

    // Known CRCs
    send("p00000001", 32'h00000001, 8'h07);
    send("p00000100", 32'h00000100, 8'h15);
    send("p00000000", 32'h00000000, 8'h00);

    // Bouncy key: low 3, high 2, low 20 -> one frame, 11 cycles after final fall
    bus.payload = 32'h12345678;
    push_frame(32'h12345678, crc8_model(32'h12345678));
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    repeat (2) @(negedge clk);
    key_n = 1'b0;
    fork
      begin repeat (20) @(negedge clk); key_n = 1'b1; end
    join_none
    seen = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      seen |= bus.tx_en;
    end
    check("key early_tx", seen, 1'b0);
    @(negedge clk);
    watch_frame("key", -1, 1'b0);
    repeat (30) @(negedge clk);

    // Glitch of 6 cycles never reaches the debounced level
    key_n = 1'b0;
    repeat (6) @(negedge clk);
    key_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); seen |= bus.tx_en | bus.busy; end
    check("glitch no_frame", seen, 1'b0);

    // Starts during DATA and GAP are dropped
    pl = 32'hA5C3_0F96;
    bus.payload = pl;
    push_frame(pl, crc8_model(pl));
    pulse_start();
    watch_frame("poke", 20, 1'b1);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= bus.tx_en | bus.busy; end
    check("poke dropped", seen, 1'b0);

    // Back-to-back: start on the first IDLE cycle after GAP
    send("b2b_a", 32'hFFFF_FFFF, crc8_model(32'hFFFF_FFFF));
    send("b2b_b", 32'h8000_0001, crc8_model(32'h8000_0001));

    // Run up to 256 completed frames to see the counter wrap
    while (exp_cnt < 256) begin
      pl = $urandom;
      send("bulk", pl, crc8_model(pl));
    end
    check("wrap frame_cnt", bus.frame_cnt, 8'h00);
    send("post_wrap", 32'h0000_00FF, crc8_model(32'h0000_00FF));

    // Reset mid-DATA aborts; later frame must carry no CRC residue
    bus.payload = 32'hFFFF_0000;
    pulse_start();
    stb = 0; cyc = 0;
    while (stb < 20 && cyc < 200) begin
      if (bus.bit_stb) stb++;
      @(negedge clk);
      cyc++;
    end
    check("mid stb_reached", stb, 20);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst tx_en", bus.tx_en, 1'b0);
    check("mid_rst busy", bus.busy, 1'b0);
    check("mid_rst frame_cnt", bus.frame_cnt, 8'h00);
    check("mid_rst outs", {bus.tx_bit, bus.bit_stb, bus.frame_done}, 3'b000);
    rst = 1'b0;
    exp_cnt = 0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= bus.tx_en | bus.busy; end
    check("mid_rst no_resume", seen, 1'b0);
    send("after_rst", 32'hDEAD_BEEF, crc8_model(32'hDEAD_BEEF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
